pal_cfg_loader: RTL
===================

# pal_cfg_loader

Byte-stream configuration loader that sits directly upstream of the PAL fabric and drives its serial configuration port. It hunts for a sync byte, accepts a fixed-length payload over a valid/ready byte interface, and serializes every payload bit MSB-first into the PAL configuration shift chain using one-cycle shift strobes. A trailing CRC-8 is checked before the apply strobe is issued, so a corrupted bitstream is never committed to the fabric.

## Interface
- CFG_BITS, 200: total configuration bits in the PAL chain (2·N·P + P·M for N=8, P=10, M=4).
- SYNC_BYTE, 8'hA5: frame start marker.
- Derived: NUM_BYTES = ceil(CFG_BITS/8) = 25; LAST_BITS = CFG_BITS − 8·(NUM_BYTES−1) = 8.

- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  incoming byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- cfg_bit  out  1  serial configuration bit to the PAL.
- cfg_shift  out  1  one-cycle strobe; PAL shifts in cfg_bit on this cycle.
- cfg_apply  out  1  one-cycle strobe; PAL commits its shifted configuration.
- busy  out  1  high from sync-byte acceptance until the frame ends (APPLY or ERR).
- done  out  1  sticky: last frame applied successfully.
- crc_err  out  1  sticky: last frame failed the CRC check.

## Operation
- States: HUNT, LOAD, SHIFT, CHECK, APPLY.
- HUNT: in_ready=1. A byte equal to SYNC_BYTE → clear done, crc_err, CRC register (init 8'h00), byte counter → LOAD, busy=1. Any other byte is consumed and discarded.
- LOAD: in_ready=1. On transfer: latch byte into shift register, update CRC with the full byte, increment byte counter → SHIFT.
- SHIFT: in_ready=0. cfg_shift=1 every cycle; cfg_bit = shift-register MSB; shift left by one per cycle. Runs 8 cycles, except the final payload byte runs LAST_BITS cycles (remaining LSBs are padding, shifted nowhere but included in CRC). Then → LOAD if bytes remain, else → CHECK.
- CHECK: in_ready=1. On transfer: compare byte with CRC register. Match → APPLY. Mismatch → crc_err=1, busy=0, → HUNT (no cfg_apply).
- APPLY: in_ready=0, cfg_apply=1 for exactly one cycle, done=1, busy=0, → HUNT.
- CRC: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over all NUM_BYTES payload bytes (not sync, not CRC byte). Byte-parallel update, combinational in one cycle.
- Bit counter 3 bits, byte counter ceil(log2(NUM_BYTES+1)) bits; no wrap beyond NUM_BYTES.
- A SYNC_BYTE value inside the payload is ordinary data; no resync mid-frame.
- cfg_bit is held at 0 whenever cfg_shift=0.

## Timing
- Reset (async assert, sync-safe deassert path is upstream): state=HUNT, in_ready=1 after reset, cfg_bit=0, cfg_shift=0, cfg_apply=0, busy=0, done=0, crc_err=0.
- Reset mid-frame: abort immediately; no cfg_apply; PAL contents partial but never applied.
- Payload byte accepted at edge t → cfg_shift high on cycles t+1 … t+8, MSB at t+1, LSB at t+8; in_ready returns high at t+9.
- in_valid may be held or gapped arbitrarily; loader stalls in LOAD/CHECK without side effects.
- Minimum frame: 1 (sync) + NUM_BYTES·9 + 1 (CRC) + 1 (apply) = 228 cycles for default parameters.
- CRC byte accepted at edge c → cfg_apply high on cycle c+1; done rises at c+1 edge; in_ready high again at c+2.
- Outputs are registered; no combinational path from in_valid/in_data to any output except in_ready (pure state decode, not dependent on in_valid).

## Test plan
- Reset then idle: rst_n low 3 cycles → all outputs 0 except in_ready=1; no cfg_shift pulses with in_valid=0.
- Good frame: 0xA5, 25×0x00, CRC 0x00 → exactly 200 cfg_shift pulses, all cfg_bit=0, one cfg_apply, done=1, crc_err=0.
- Bit order: 0xA5, payload byte0=0x81 then 24×0x00, correct CRC from reference model → cfg_bit sequence 1,0,0,0,0,0,0,1 on first 8 shifts; apply issued.
- Bad CRC: 0xA5, 25×0x00, CRC 0x01 → 200 shifts, no cfg_apply, crc_err=1, done=0, back in HUNT.
- Junk + backpressure: 0x00, 0x5A before 0xA5 discarded; payload delivered with random in_valid gaps → shift count and apply identical to gapless case.
- Reset mid-frame: assert rst_n low after 10 payload bytes → outputs reset same cycle, no cfg_apply; following good frame applies normally.

Source files
------------

// File: rtl/pal_cfg_loader.sv
// Byte-stream configuration loader for the PAL fabric: hunts a sync byte, serializes a fixed-length
// payload MSB-first onto the PAL shift chain and applies it only if the trailing CRC-8 matches.
module pal_cfg_loader #(
    parameter int unsigned CFG_BITS  = 200,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_bit,
    output logic       cfg_shift,
    output logic       cfg_apply,
    output logic       busy,
    output logic       done,
    output logic       crc_err
);

    localparam int unsigned NUM_BYTES = (CFG_BITS + 7) / 8;
    localparam int unsigned LAST_BITS = CFG_BITS - 8 * (NUM_BYTES - 1);
    localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES);
    localparam logic [2:0]       FULL_IDX  = 3'd7;
    localparam logic [2:0]       LAST_IDX  = 3'(LAST_BITS - 1);

    typedef enum logic [2:0] {
        StHunt,
        StLoad,
        StShift,
        StCheck,
        StApply
    } state_t;

    state_t           state;
    logic [7:0]       shreg;
    logic [7:0]       crc;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [2:0]       last_idx;
    logic             xfer;
    logic [7:0]       crc_upd;

    // CRC-8, poly 0x07, MSB-first, whole byte folded in one cycle
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // in_ready is a pure state decode and never looks at in_valid
    assign in_ready = (state == StHunt) || (state == StLoad) || (state == StCheck);
    assign xfer     = in_valid && in_ready;
    assign crc_upd  = crc8_byte(crc, in_data);
    // The final payload byte may carry padding LSBs that are never shifted out
    assign last_idx = (byte_cnt == LAST_BYTE) ? LAST_IDX : FULL_IDX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StHunt;
            shreg     <= 8'h00;
            crc       <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            cfg_bit   <= 1'b0;
            cfg_shift <= 1'b0;
            cfg_apply <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            cfg_apply <= 1'b0;
            unique case (state)
                StHunt: begin
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        done     <= 1'b0;
                        crc_err  <= 1'b0;
                        crc      <= 8'h00;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= StLoad;
                    end
                end
                StLoad: begin
                    if (xfer) begin
                        // MSB goes out on the very next cycle; the rest waits in shreg
                        cfg_bit   <= in_data[7];
                        cfg_shift <= 1'b1;
                        shreg     <= {in_data[6:0], 1'b0};
                        bit_cnt   <= 3'd0;
                        crc       <= crc_upd;
                        byte_cnt  <= byte_cnt + 1'b1;
                        state     <= StShift;
                    end
                end
                StShift: begin
                    if (bit_cnt == last_idx) begin
                        cfg_shift <= 1'b0;
                        cfg_bit   <= 1'b0;
                        state     <= (byte_cnt == LAST_BYTE) ? StCheck : StLoad;
                    end else begin
                        cfg_bit <= shreg[7];
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                StCheck: begin
                    if (xfer) begin
                        if (in_data == crc) begin
                            cfg_apply <= 1'b1;
                            state     <= StApply;
                        end else begin
                            crc_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= StHunt;
                        end
                    end
                end
                StApply: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StHunt;
                end
                default: state <= StHunt;
            endcase
        end
    end

endmodule
